ddr2_app_traffic_gen: RTL and testbench

DDR2_APP_TRAFFIC_GEN -- requirements
Module: ddr2_app_traffic_gen

---
 rtl/ddr2_app_pkg.sv | 18 +
 rtl/ddr2_app_pattern.sv | 24 ++
 rtl/ddr2_app_traffic_gen.sv | 181 ++++++++++++++++++
 tb/tb_ddr2_app_traffic_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_app_pkg.sv
// Shared definitions for the DDR2 application-side traffic generator:
// FSM state encoding, address-FIFO command codes and pattern word width.
package ddr2_app_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_CMD  = 3'd1,
    WR_DATA = 3'd2,
    RD_CMD  = 3'd3,
    RD_WAIT = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam int         PAT_W  = 16;

endpackage

// File: rtl/ddr2_app_pattern.sv
// Pattern word generator: the 16-bit value (start_addr + index) replicated
// across the whole application data word.
module ddr2_app_pattern
  import ddr2_app_pkg::*;
#(
  parameter int APPDATA_WIDTH = 144
) (
  input  logic [PAT_W-1:0]         start_addr,
  input  logic [PAT_W-1:0]         index,
  output logic [APPDATA_WIDTH-1:0] word
);

  logic [PAT_W-1:0] w_val;

  assign w_val = start_addr + index;

  genvar gi;
  generate
    for (gi = 0; gi < APPDATA_WIDTH / PAT_W; gi++) begin : g_rep
      assign word[gi*PAT_W +: PAT_W] = w_val;
    end
  endgenerate

endmodule

// File: rtl/ddr2_app_traffic_gen.sv
// DDR2 MIG application-port traffic generator: burst writes of an address
// pattern, burst reads, and (with DDR2_APP_CHECK_EN) read-data checking.
module ddr2_app_traffic_gen
  import ddr2_app_pkg::*;
#(
  parameter int APPDATA_WIDTH = 144,
  parameter int BURST_LEN     = 4,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                       clk0,
  input  logic                       rst0,
  input  logic                       phy_init_done,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [30:0]                req_addr,
  input  logic [LEN_WIDTH-1:0]       req_len,
  output logic [2:0]                 app_af_cmd,
  output logic [30:0]                app_af_addr,
  output logic                       app_af_wren,
  input  logic                       app_af_afull,
  output logic                       app_wdf_wren,
  output logic [APPDATA_WIDTH-1:0]   app_wdf_data,
  output logic [APPDATA_WIDTH/8-1:0] app_wdf_mask_data,
  input  logic                       app_wdf_afull,
  input  logic                       rd_data_valid,
  input  logic [APPDATA_WIDTH-1:0]   rd_data_fifo_out,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                err_cnt
);

  localparam int WPB = BURST_LEN / 2;
  localparam int CW  = LEN_WIDTH + 3;

  state_t                     r_state;
  logic [PAT_W-1:0]           r_pat_base;
  logic [30:0]                r_baddr;
  logic [LEN_WIDTH-1:0]       r_len;
  logic [LEN_WIDTH-1:0]       r_burst;
  logic [CW-1:0]              r_k;
  logic [CW-1:0]              r_rcnt;
  logic [2:0]                 r_beat;
  logic [2:0]                 r_af_cmd;
  logic [30:0]                r_af_addr;
  logic                       r_af_wren;
  logic                       r_wdf_wren;
  logic [APPDATA_WIDTH-1:0]   r_wdf_data;
  logic                       r_done;

  logic                       w_accept;
  logic                       w_rd_count;
  logic [CW-1:0]              w_total;
  logic [APPDATA_WIDTH-1:0]   w_wr_word;

  // Gating with rst0 keeps req_ready low for the whole reset, even in IDLE.
  assign req_ready  = (r_state == IDLE) && phy_init_done && !rst0;
  assign w_accept   = req_ready && req_valid;
  assign w_rd_count = rd_data_valid && ((r_state == RD_CMD) || (r_state == RD_WAIT));
  assign w_total    = CW'(r_len) * CW'(WPB);

  ddr2_app_pattern #(.APPDATA_WIDTH(APPDATA_WIDTH)) u_wr_pat (
    .start_addr (r_pat_base),
    .index      (PAT_W'(r_k)),
    .word       (w_wr_word)
  );

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_state    <= IDLE;
      r_pat_base <= '0;
      r_baddr    <= '0;
      r_len      <= '0;
      r_burst    <= '0;
      r_k        <= '0;
      r_rcnt     <= '0;
      r_beat     <= '0;
      r_af_cmd   <= CMD_WR;
      r_af_addr  <= '0;
      r_af_wren  <= 1'b0;
      r_wdf_wren <= 1'b0;
      r_wdf_data <= '0;
      r_done     <= 1'b0;
    end else begin
      r_af_wren  <= 1'b0;
      r_wdf_wren <= 1'b0;
      r_done     <= 1'b0;
      if (w_rd_count) r_rcnt <= r_rcnt + 1'b1;
      case (r_state)
        IDLE: if (w_accept) begin
          r_pat_base <= req_addr[PAT_W-1:0];
          r_baddr    <= req_addr;
          r_len      <= req_len;
          r_burst    <= '0;
          r_k        <= '0;
          r_rcnt     <= '0;
          r_beat     <= '0;
          if (req_len == '0)   r_state <= FIN;
          else if (req_write)  r_state <= WR_CMD;
          else                 r_state <= RD_CMD;
        end
        WR_CMD: if (!app_af_afull && !app_wdf_afull) begin
          r_af_wren  <= 1'b1;
          r_wdf_wren <= 1'b1;
          r_af_cmd   <= CMD_WR;
          r_af_addr  <= r_baddr;
          r_wdf_data <= w_wr_word;
          r_k        <= r_k + 1'b1;
          r_baddr    <= r_baddr + 31'(BURST_LEN);
          r_beat     <= 3'd1;
          r_state    <= WR_DATA;
        end
        WR_DATA: if (!app_wdf_afull) begin
          r_wdf_wren <= 1'b1;
          r_wdf_data <= w_wr_word;
          r_k        <= r_k + 1'b1;
          if (r_beat == 3'(WPB - 1)) begin
            r_beat  <= '0;
            r_burst <= r_burst + 1'b1;
            r_state <= (r_burst == r_len - 1'b1) ? FIN : WR_CMD;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        RD_CMD: if (!app_af_afull) begin
          r_af_wren <= 1'b1;
          r_af_cmd  <= CMD_RD;
          r_af_addr <= r_baddr;
          r_baddr   <= r_baddr + 31'(BURST_LEN);
          r_burst   <= r_burst + 1'b1;
          if (r_burst == r_len - 1'b1) r_state <= RD_WAIT;
        end
        // Registered count already includes a word that landed with the last command.
        RD_WAIT: if (r_rcnt == w_total) r_state <= FIN;
        FIN: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign app_af_cmd        = r_af_cmd;
  assign app_af_addr       = r_af_addr;
  assign app_af_wren       = r_af_wren;
  assign app_wdf_wren      = r_wdf_wren;
  assign app_wdf_data      = r_wdf_data;
  assign app_wdf_mask_data = '0;
  assign busy              = (r_state != IDLE);
  assign done              = r_done;

`ifdef DDR2_APP_CHECK_EN
  logic [APPDATA_WIDTH-1:0] w_chk_word;
  logic [15:0]              r_err_cnt;

  ddr2_app_pattern #(.APPDATA_WIDTH(APPDATA_WIDTH)) u_chk_pat (
    .start_addr (r_pat_base),
    .index      (PAT_W'(r_rcnt)),
    .word       (w_chk_word)
  );

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_err_cnt <= '0;
    end else if (w_accept && !req_write) begin
      r_err_cnt <= '0;
    end else if (w_rd_count && (rd_data_fifo_out != w_chk_word) && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused_rd_data;

  assign w_unused_rd_data = ^rd_data_fifo_out;
  assign err_cnt          = '0;
`endif

endmodule

// File: tb/tb_ddr2_app_traffic_gen.sv
// Self-checking bench for ddr2_app_traffic_gen: queue-based model of expected
// FIFO pushes, directed scenarios, then randomized transactions.
module tb_ddr2_app_traffic_gen;

  localparam int DW  = 144;
  localparam int BL  = 4;
  localparam int LW  = 8;
  localparam int WPB = BL / 2;

  logic           clk0 = 1'b0;
  logic           rst0 = 1'b1;
  logic           phy_init_done = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_write = 1'b0;
  logic [30:0]    req_addr = '0;
  logic [LW-1:0]  req_len = '0;
  logic           app_af_afull = 1'b0;
  logic           app_wdf_afull = 1'b0;
  logic           rd_data_valid = 1'b0;
  logic [DW-1:0]  rd_data_fifo_out = '0;

  logic           req_ready;
  logic [2:0]     app_af_cmd;
  logic [30:0]    app_af_addr;
  logic           app_af_wren;
  logic           app_wdf_wren;
  logic [DW-1:0]  app_wdf_data;
  logic [DW/8-1:0] app_wdf_mask_data;
  logic           busy;
  logic           done;
  logic [15:0]    err_cnt;

  ddr2_app_traffic_gen #(.APPDATA_WIDTH(DW), .BURST_LEN(BL), .LEN_WIDTH(LW)) dut (
    .clk0              (clk0),
    .rst0              (rst0),
    .phy_init_done     (phy_init_done),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_len           (req_len),
    .app_af_cmd        (app_af_cmd),
    .app_af_addr       (app_af_addr),
    .app_af_wren       (app_af_wren),
    .app_af_afull      (app_af_afull),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_mask_data (app_wdf_mask_data),
    .app_wdf_afull     (app_wdf_afull),
    .rd_data_valid     (rd_data_valid),
    .rd_data_fifo_out  (rd_data_fifo_out),
    .busy              (busy),
    .done              (done),
    .err_cnt           (err_cnt)
  );

  always #5 clk0 = ~clk0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk0) cyc <= cyc + 1;

  // Model state: expected pushes in order, plus logs of what the DUT pushed.
  logic [33:0]   af_q[$];
  logic [DW-1:0] wdf_q[$];
  logic [33:0]   af_log[$];
  logic [DW-1:0] wdf_log[$];
  logic [33:0]   mon_af_e;
  logic [DW-1:0] mon_wdf_e;
  int done_cnt = 0, done_cyc = -1, last_wdf_cyc = -1, wdf_push_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [30:0] a, input int k);
    logic [15:0] v;
    v = a[15:0] + 16'(k);
    return {(DW/16){v}};
  endfunction

  always @(negedge clk0) begin
    if (!rst0) begin
      if (app_af_wren) begin
        af_log.push_back({app_af_cmd, app_af_addr});
        if (af_q.size() == 0) chk("af_unexpected_push", 1, 0);
        else begin
          mon_af_e = af_q.pop_front();
          chk("af_push", {app_af_cmd, app_af_addr}, mon_af_e);
        end
      end
      if (app_wdf_wren) begin
        wdf_log.push_back(app_wdf_data);
        wdf_push_cnt++;
        last_wdf_cyc = cyc;
        if (wdf_q.size() == 0) chk("wdf_unexpected_push", 1, 0);
        else begin
          mon_wdf_e = wdf_q.pop_front();
          chk("wdf_push", app_wdf_data, mon_wdf_e);
        end
        chk("wdf_mask", DW'(app_wdf_mask_data), '0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic do_req(input bit wr, input logic [30:0] addr, input int len, output int acc);
    int t = 0;
    @(negedge clk0);
    while (!req_ready && t < 200) begin
      @(negedge clk0);
      t++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = LW'(len);
    acc = cyc;
    @(negedge clk0);
    req_valid = 1'b0;
  endtask

  // mode 0: no backpressure, 1: random afull, 2: wdf_afull high 5 cycles after first word
  task automatic run_txn(input bit wr, input logic [30:0] addr, input int len,
                         input int corrupt, input int mode, output int acc);
    int total, sent, t, d0, wp0, stall, exp_err;
    total = len * WPB; sent = 0; t = 0; stall = 0; exp_err = 0;
    for (int n = 0; n < len; n++) af_q.push_back({wr ? 3'b000 : 3'b001, 31'(addr + 31'(n * BL))});
    if (wr) for (int k = 0; k < total; k++) wdf_q.push_back(pat(addr, k));
    d0 = done_cnt; wp0 = wdf_push_cnt;
    do_req(wr, addr, len, acc);
    while (done_cnt == d0 && t < 3000) begin
      if (mode == 1) begin
        app_af_afull  = ($urandom_range(0, 3) == 0);
        app_wdf_afull = ($urandom_range(0, 3) == 0);
      end else if (mode == 2) begin
        if (stall == 0 && wdf_push_cnt > wp0) stall = 1;
        app_wdf_afull = (stall >= 1 && stall <= 5);
        if (stall >= 1) stall++;
      end
      if (!wr) begin
        rd_data_valid = (sent < total) && ($urandom_range(0, 1) == 1);
        if (rd_data_valid) begin
          rd_data_fifo_out = pat(addr, sent);
          if (sent == corrupt) begin
            rd_data_fifo_out[0] = ~rd_data_fifo_out[0];
            exp_err++;
          end
          sent++;
        end
      end
      @(negedge clk0);
      t++;
    end
    app_af_afull = 1'b0; app_wdf_afull = 1'b0; rd_data_valid = 1'b0;
    repeat (2) @(negedge clk0);
    chk("done_seen", DW'(done_cnt != d0), 1);
    chk("done_single_pulse", DW'(done_cnt - d0), 1);
    chk("af_all_pushed", DW'(af_q.size()), 0);
    chk("wdf_all_pushed", DW'(wdf_q.size()), 0);
    chk("busy_after_done", DW'(busy), 0);
    if (!wr && len > 0) begin
`ifdef DDR2_APP_CHECK_EN
      chk("err_cnt", DW'(err_cnt), DW'(exp_err));
`else
      chk("err_cnt", DW'(err_cnt), 0);
`endif
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, DW'(req_ready), 0);
    chk({tag, "_busy"}, DW'(busy), 0);
    chk({tag, "_done"}, DW'(done), 0);
    chk({tag, "_af_wren"}, DW'(app_af_wren), 0);
    chk({tag, "_wdf_wren"}, DW'(app_wdf_wren), 0);
    chk({tag, "_af_addr"}, DW'(app_af_addr), 0);
    chk({tag, "_af_cmd"}, DW'(app_af_cmd), 0);
    chk({tag, "_wdf_data"}, app_wdf_data, 0);
    chk({tag, "_err_cnt"}, DW'(err_cnt), 0);
  endtask

  initial begin
    int acc, wp0, d0;
    phy_init_done = 1'b1;
    repeat (3) @(negedge clk0);
    chk_outputs_zero("reset");
    rst0 = 1'b0;
    #1 chk("ready_after_reset", DW'(req_ready), 1);

    // Directed write: literal pins on addresses, data and done timing.
    af_log.delete(); wdf_log.delete();
    run_txn(1'b1, 31'h100, 2, -1, 0, acc);
    chk("lit_af0", DW'(af_log[0]), DW'({3'b000, 31'h100}));
    chk("lit_af1", DW'(af_log[1]), DW'({3'b000, 31'h104}));
    chk("lit_wdf0", wdf_log[0], {9{16'h0100}});
    chk("lit_wdf3", wdf_log[3], {9{16'h0103}});
    chk("done_after_last_wdf", DW'(done_cyc), DW'(last_wdf_cyc + 1));

    af_log.delete();
    run_txn(1'b0, 31'h100, 2, -1, 0, acc);
    chk("lit_rd_af1", DW'(af_log[1]), DW'({3'b001, 31'h104}));
    run_txn(1'b0, 31'h100, 2, 2, 0, acc);

    wp0 = wdf_push_cnt;
    run_txn(1'b1, 31'h100, 2, -1, 2, acc);
    chk("stall_word_total", DW'(wdf_push_cnt - wp0), 4);

    wp0 = wdf_push_cnt;
    run_txn(1'b1, 31'h300, 0, -1, 0, acc);
    chk("len0_done_latency", DW'(done_cyc), DW'(acc + 2));
    chk("len0_no_wdf", DW'(wdf_push_cnt - wp0), 0);

    // Reset while waiting for read data (only half the words returned).
    d0 = done_cnt;
    for (int n = 0; n < 2; n++) af_q.push_back({3'b001, 31'(31'h200 + 31'(n * BL))});
    do_req(1'b0, 31'h200, 2, acc);
    for (int i = 0; i < 6; i++) begin
      rd_data_valid = (i < 2);
      rd_data_fifo_out = pat(31'h200, i);
      @(negedge clk0);
    end
    rd_data_valid = 1'b0;
    chk("rdwait_busy", DW'(busy), 1);
    chk("rdwait_no_done", DW'(done_cnt - d0), 0);
    chk("rdwait_af_pushed", DW'(af_q.size()), 0);
    phy_init_done = 1'b0;
    rst0 = 1'b1;
    #1 chk_outputs_zero("midreset");
    repeat (2) @(negedge clk0);
    rst0 = 1'b0;
    #1 chk("ready_low_without_phy", DW'(req_ready), 0);
    repeat (2) @(negedge clk0);
    phy_init_done = 1'b1;
    #1 chk("ready_back_with_phy", DW'(req_ready), 1);

    // Randomized transactions, including addresses that wrap past 2^31.
    for (int i = 0; i < 24; i++) begin
      logic [30:0] a;
      bit w;
      int l, c;
      w = $urandom_range(0, 1) == 1;
      a = (i % 6 == 5) ? 31'h7FFF_FFF8 : 31'($urandom);
      l = $urandom_range(0, 5);
      c = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 9) : -1;
      run_txn(w, a, l, c, 1, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
